// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit for a single-cycle core.
// Requests imem at pc, then holds the returned word until the core retires it.
// The next pc comes from the core (pc_new) and is loaded on retire.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc                address of instruction being fetched / held
//   pc_new            next pc from core, sampled on retire
//   instr             fetched instruction word
//   instr_valid       instr/pc valid for execution
//   cpu_ready         core retires the held instruction this cycle
//   imem_req          memory read request
//   imem_addr         memory read address (always pc)
//   imem_ack          memory returns imem_rdata this cycle
//   imem_rdata        instruction word from memory
//   retired           retired-instruction counter (wraps)
//   stall_cycles      wait cycles on the current fetch (saturates at 255)
//   fetch_err         misaligned pc_new trapped
//
// Build option: define INSTR_FETCH_ALIGN_TRAP_EN to trap misaligned pc_new
// into a sticky ERR state; otherwise pc_new[1:0] is cleared on load.

module instr_fetch (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] pc_new,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        cpu_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] retired,
    output logic [7:0]  stall_cycles,
    output logic        fetch_err
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STALL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [XLEN-1:0]      pc_d, instr_d, retired_d;
    logic [STALL_W-1:0]   stall_d;
    logic                 fetch_err_d;

    // Memory address is the registered pc itself.
    assign imem_addr = pc;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc;
        instr_d     = instr;
        retired_d   = retired;
        stall_d     = stall_cycles;
        fetch_err_d = fetch_err;

        case (state_q)
            IDLE: state_d = REQ;

            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end else if (stall_cycles != {STALL_W{1'b1}}) begin
                    stall_d = STALL_W'(stall_cycles + STALL_W'(1));
                end
            end

            HOLD: begin
                if (cpu_ready) begin
                    retired_d = XLEN'(retired + XLEN'(1));
                    stall_d   = '0;
                    state_d   = REQ;
`ifdef INSTR_FETCH_ALIGN_TRAP_EN
                    pc_d = pc_new;
                    if (pc_new[1:0] != 2'b00) begin
                        state_d     = ERR;
                        fetch_err_d = 1'b1;
                    end
`else
                    // Word-align: low address bits are dropped on load.
                    pc_d = pc_new & ~XLEN'(3);
`endif
                end
            end

`ifdef INSTR_FETCH_ALIGN_TRAP_EN
            ERR: state_d = ERR;   // sticky until reset
`else
            ERR: state_d = IDLE;  // unreachable; recover if ever entered
`endif

            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; request/valid decode from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc           <= '0;
            instr        <= '0;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b0;
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            state_q      <= state_d;
            pc           <= pc_d;
            instr        <= instr_d;
            instr_valid  <= (state_d == HOLD);
            imem_req     <= (state_d == REQ);
            retired      <= retired_d;
            stall_cycles <= stall_d;
        end
    end

`ifdef INSTR_FETCH_ALIGN_TRAP_EN
    // Sticky trap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= fetch_err_d;
        end
    end
`else
    assign fetch_err = 1'b0;
    logic unused_fetch_err;
    assign unused_fetch_err = fetch_err_d;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port pc  output  32  address of the instruction currently being fetched or held.
REQ-004 SHALL have port pc_new  input  32  next PC from the single-cycle core, sampled only on retire.
REQ-005 SHALL have port instr  output  32  fetched instruction word presented to the core.
REQ-006 SHALL have port instr_valid  output  1  instr and pc are valid for execution.
REQ-007 SHALL have port cpu_ready  input  1  the core retires the held instruction this cycle.
REQ-008 SHALL have port imem_req  output  1  instruction memory read request.
REQ-009 SHALL have port imem_addr  output  32  read address, always equal to pc.
REQ-010 SHALL have port imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-011 SHALL have port imem_rdata  input  32  instruction word from memory.
REQ-012 SHALL have port retired  output  32  count of retired instructions.
REQ-013 SHALL have port stall_cycles  output  8  cycles spent waiting for imem_ack on the current fetch.
REQ-014 SHALL have port fetch_err  output  1  misaligned pc_new trapped (macro-dependent).

Function
REQ-015 SHALL implement FSM states IDLE, REQ, HOLD, ERR.
REQ-016 IDLE SHALL go to REQ unconditionally on the next clock edge.
REQ-017 In REQ, imem_req SHALL be 1 and stall_cycles SHALL increment by 1 per cycle without imem_ack, saturating at 255.
REQ-018 In REQ with imem_ack=1, the block SHALL register instr<=imem_rdata and go to HOLD; same-cycle ack (zero-wait memory) SHALL be legal, giving 1-cycle REQ->valid latency.
REQ-019 In HOLD, instr_valid SHALL be 1, imem_req SHALL be 0, and instr and pc SHALL stay stable until cpu_ready=1.
REQ-020 In HOLD with cpu_ready=1, the block SHALL load pc<=pc_new, increment retired (wraps 2^32-1 -> 0), clear stall_cycles, and go to REQ.
REQ-021 imem_ack outside REQ and cpu_ready outside HOLD SHALL be ignored.
REQ-022 instr_valid SHALL be 0 in IDLE, REQ and ERR.
REQ-023 pc_new SHALL be taken verbatim; no internal +4 arithmetic.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, pc=0, instr=0, instr_valid=0, imem_req=0, retired=0, stall_cycles=0, fetch_err=0.
REQ-025 Reset asserted mid-fetch (REQ or HOLD) SHALL abandon the fetch; a late imem_ack after release SHALL be ignored unless the FSM is again in REQ.

Configuration
REQ-026 Macro INSTR_FETCH_ALIGN_TRAP_EN SHALL control misalignment trapping.
REQ-027 With the macro defined, a retire with pc_new[1:0]!=0 SHALL go to ERR, set fetch_err=1, still load pc and increment retired; ERR SHALL be left only by reset.
REQ-028 Without the macro, fetch_err SHALL be tied to 0, ERR SHALL be unreachable, and pc_new[1:0] SHALL be forced to 00 when loaded.

Verification
REQ-029 Reset release, imem_ack held 1, imem_rdata=0x20080005 -> IDLE 1 cycle, REQ 1 cycle, then instr_valid=1, pc=0, instr=0x20080005.
REQ-030 REQ with ack delayed 3 cycles -> stall_cycles reads 1,2,3, instr_valid=0 throughout, valid on cycle after ack.
REQ-031 HOLD, cpu_ready=0 for 4 cycles, imem_rdata toggling -> instr unchanged; then cpu_ready=1, pc_new=0x00000040 -> pc=0x40, retired=1, imem_addr=0x40.
REQ-032 With macro: retire pc_new=0x00000042 -> fetch_err=1, state ERR, imem_req=0 until rst_n=0; without macro: pc=0x40, fetch_err=0.
REQ-033 rst_n pulsed low while in REQ, ack arrives 1 cycle after release -> ignored (state IDLE), pc=0, retired=0.
REQ-034 Force retired=0xFFFFFFFF (via 2^32 retires or backdoor), retire once -> retired=0x00000000.
